// File: rtl/seq_sdiv_if.sv
// Handshake bundle for seq_sdiv: operand channel (in_*) and result channel (out_*).
// The remainder signal exists only when SDIV_REM_EN is defined.
interface seq_sdiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic             ex;
`ifdef SDIV_REM_EN
    logic [WIDTH-1:0] remainder;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, ex, remainder
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, ex, remainder
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, ex
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, ex
    );
`endif
endinterface

// File: rtl/seq_sdiv.sv
// Multi-cycle signed restoring divider, one quotient bit per clock, truncating toward zero.
// Define SDIV_REM_EN to add the registered, sign-corrected remainder output.
module seq_sdiv #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clock,
    input  logic      resetn,
    seq_sdiv_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_q_q, neg_q_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic               ex_q, ex_d;
    logic               out_valid_q, out_valid_d;
`ifdef SDIV_REM_EN
    logic               neg_r_q, neg_r_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
`endif

    logic [WIDTH-1:0]   dvnd_mag, dvsr_mag;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_keep;

    // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
    assign dvnd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvsr_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_keep  = rem_shift >= {1'b0, dvsr_q};
    assign rem_diff  = rem_shift[WIDTH-1:0] - dvsr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_q_d     = neg_q_q;
        quotient_d  = quotient_q;
        ex_d        = ex_q;
        out_valid_d = out_valid_q;
`ifdef SDIV_REM_EN
        neg_r_d     = neg_r_q;
        remainder_d = remainder_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    neg_q_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    quo_d   = dvnd_mag;
                    dvsr_d  = dvsr_mag;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
`ifdef SDIV_REM_EN
                    neg_r_d = bus.dividend[WIDTH-1];
`endif
                    if (bus.divisor == '0) begin
                        quotient_d = '0;
                        ex_d       = 1'b1;
`ifdef SDIV_REM_EN
                        remainder_d = bus.dividend;
`endif
                        state_d    = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = rem_keep ? rem_diff : rem_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], rem_keep};
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                quotient_d  = neg_q_q ? -quo_q : quo_q;
                ex_d        = 1'b0;
                out_valid_d = 1'b1;
`ifdef SDIV_REM_EN
                remainder_d = neg_r_q ? -rem_q : rem_q;
`endif
                state_d     = StDone;
            end
            StDone: begin
                // Divide-by-zero enters with out_valid low; raise it one edge later.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_q_q     <= 1'b0;
            quotient_q  <= '0;
            ex_q        <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SDIV_REM_EN
            neg_r_q     <= 1'b0;
            remainder_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_q_q     <= neg_q_d;
            quotient_q  <= quotient_d;
            ex_q        <= ex_d;
            out_valid_q <= out_valid_d;
`ifdef SDIV_REM_EN
            neg_r_q     <= neg_r_d;
            remainder_q <= remainder_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.ex        = ex_q;
`ifdef SDIV_REM_EN
    assign bus.remainder = remainder_q;
`endif

endmodule

// File: tb/tb_seq_sdiv.sv
// Scoreboard bench for seq_sdiv (WIDTH=32): driver pushes expected results, a monitor
// pops and checks them, including accept-to-valid latency, when the DUT presents a result.
module tb_seq_sdiv;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ex;
        int           lat;
        int           acc;
    } exp_t;

    logic clock;
    logic resetn;
    int   total;
    int   bad;
    int   cyc;
    logic prev_ov;
    exp_t sb[$];

    seq_sdiv_if #(.WIDTH(W)) bus ();

    seq_sdiv #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, payload on the retiring cycle.
    always @(negedge clock) begin
        if (!resetn) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got out_valid=1 want no result pending");
                end else begin
                    chk("latency", W'(cyc - sb[0].acc), W'(sb[0].lat));
                end
            end
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", bus.quotient, e.q);
                chk("ex", W'(bus.ex), W'(e.ex));
`ifdef SDIV_REM_EN
                chk("remainder", bus.remainder, e.r);
`endif
            end
            prev_ov = bus.out_valid;
        end
    end

    // Issue one division (called shortly after a posedge); returns just after the accept edge.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                          input logic [W-1:0] r, input logic ex, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", W'(bus.in_ready), W'(1));
            return;
        end
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        e.q   = q;
        e.r   = r;
        e.ex  = ex;
        e.lat = lat;
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("drain", W'(sb.size()), W'(0));
    endtask

    initial begin
        logic signed [W-1:0] ra, rb;
        logic [W-1:0]        hq;
        int                  n;
        total = 0;
        bad   = 0;
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", W'(bus.in_ready), W'(1));
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_quotient", bus.quotient, '0);
        chk("rst_ex", W'(bus.ex), W'(0));
`ifdef SDIV_REM_EN
        chk("rst_remainder", bus.remainder, '0);
`endif
        resetn = 1'b1;
        @(posedge clock);
        #1;

        do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        do_div(-32'sd100, 32'd7, 32'hFFFF_FFF2, -32'sd2, 1'b0, 33);
        do_div(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
        do_div(-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 33);
        do_div(32'd7, 32'd0, 32'd0, 32'd7, 1'b1, 1);
        do_div(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        do_div(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);
        do_div(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, 33);
        drain();

        // Back-pressure: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        do_div(32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 33);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        hq = 32'd111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold_out_valid", W'(bus.out_valid), W'(1));
            chk("hold_in_ready", W'(bus.in_ready), W'(0));
            chk("hold_quotient", bus.quotient, hq);
            @(posedge clock);
            #1;
            bus.in_valid = i[0];
            bus.dividend = 32'd55;
            bus.divisor  = 32'd5;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clock);
        #1;
        chk("retire_in_ready", W'(bus.in_ready), W'(1));
        chk("retire_out_valid", W'(bus.out_valid), W'(0));
        bus.in_valid = 1'b0;
        drain();

        // Reset in the middle of an iteration abandons the division.
        do_div(32'd5000, 32'd7, 32'd714, 32'd2, 1'b0, 33);
        repeat (15) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst_out_valid", W'(bus.out_valid), W'(0));
        chk("midrst_in_ready", W'(bus.in_ready), W'(1));
        sb.delete();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        do_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
        drain();

        for (int i = 0; i < 6; i++) begin
            ra = $signed($urandom);
            rb = $signed($urandom);
            if (i % 2 == 1) rb = {{20{rb[W-1]}}, rb[11:0]};
            if (rb == 0) rb = 3;
            if (ra == 32'sh8000_0000 && rb == -1) rb = 2;
            do_div(ra, rb, ra / rb, ra % rb, 1'b0, 33);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
